// File: rtl/hilo_muldiv_ctrl_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// hilo_pkg: shared encodings for the HI/LO mul/div sequencer. Rev 1.0
// ------------------------------------------------------------------
package hilo_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;
endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_ctrl_step.sv
`default_nettype none
// ------------------------------------------------------------------
// muldiv_step: one shift-add or restoring-divide iteration.  Rev 1.0
// ------------------------------------------------------------------
module muldiv_step #(
  parameter int WIDTH = hilo_pkg::DEF_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               div_mode,
  output logic [2*WIDTH-1:0] acc_next
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, operand};
    acc_next = {1'b0, acc[2*WIDTH-1:1]};
    if (div_mode) begin
      // Remainder stays below the divisor, so diff[WIDTH] is a clean borrow flag.
      if (!diff[WIDTH])
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else if (acc[0]) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end
endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// hilo_muldiv_ctrl: iterative HI/LO mul/div sequencer for EXE. Rev 1.0
// ------------------------------------------------------------------
module hilo_muldiv_ctrl
  import hilo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             Start_IN,
  input  logic [2:0]       Op_IN,
  input  logic [WIDTH-1:0] OperandA_IN,
  input  logic [WIDTH-1:0] OperandB_IN,
  input  logic             ReadHiLo_IN,
  input  logic             Flush_IN,
  output logic             Stall_OUT,
  output logic             Busy_OUT,
  output logic             Done_OUT,
  output logic             DivByZero_OUT,
  output logic [WIDTH-1:0] HI_OUT,
  output logic [WIDTH-1:0] LO_OUT
);
  localparam int CW = (WIDTH == DEF_WIDTH) ? CNT_W : $clog2(WIDTH);

  logic [1:0]         state;
  logic [CW-1:0]      counter;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               neg_lo;
  logic               neg_hi;
  logic               div_op;
  logic               dbz;
  logic               busy;
  logic               signed_op;
  logic               a_neg;
  logic               b_neg;

  assign busy      = (state != ST_IDLE);
  assign signed_op = (Op_IN == OP_MULT) || (Op_IN == OP_DIV);
  assign a_neg     = signed_op & OperandA_IN[WIDTH-1];
  assign b_neg     = signed_op & OperandB_IN[WIDTH-1];
  assign a_mag     = a_neg ? -OperandA_IN : OperandA_IN;
  assign b_mag     = b_neg ? -OperandB_IN : OperandB_IN;

  assign Busy_OUT      = busy;
  assign Stall_OUT     = busy & (Start_IN | ReadHiLo_IN);
  assign Done_OUT      = (state == ST_FIX) & ~Flush_IN;
  assign DivByZero_OUT = dbz;
  assign HI_OUT        = hi;
  assign LO_OUT        = lo;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (operand),
    .div_mode (state == ST_DIV),
    .acc_next (acc_next)
  );

  // Products negate as a whole double word; quotient and remainder separately.
  always_comb begin
    prod   = neg_lo ? -acc : acc;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (div_op) begin
      fix_hi = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      fix_lo = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state   <= ST_IDLE;
      counter <= '0;
      acc     <= '0;
      operand <= '0;
      hi      <= '0;
      lo      <= '0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
      div_op  <= 1'b0;
      dbz     <= 1'b0;
    end else begin
      dbz <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start_IN && !Flush_IN) begin
            case (Op_IN)
              OP_MTHI: hi <= OperandA_IN;
              OP_MTLO: lo <= OperandA_IN;
              OP_MULT, OP_MULTU: begin
                acc     <= {{WIDTH{1'b0}}, a_mag};
                operand <= b_mag;
                neg_lo  <= a_neg ^ b_neg;
                neg_hi  <= 1'b0;
                div_op  <= 1'b0;
                counter <= CW'(WIDTH - 1);
                state   <= ST_MUL;
              end
              OP_DIV, OP_DIVU: begin
                if (OperandB_IN == '0) begin
                  hi  <= OperandA_IN;
                  lo  <= '1;
                  dbz <= 1'b1;
                end else begin
                  acc     <= {{WIDTH{1'b0}}, a_mag};
                  operand <= b_mag;
                  neg_lo  <= a_neg ^ b_neg;
                  neg_hi  <= a_neg;
                  div_op  <= 1'b1;
                  counter <= CW'(WIDTH - 1);
                  state   <= ST_DIV;
                end
              end
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          if (Flush_IN) begin
            state <= ST_IDLE;
          end else begin
            acc     <= acc_next;
            counter <= counter - CW'(1);
            if (counter == '0)
              state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (!Flush_IN) begin
            hi <= fix_hi;
            lo <= fix_lo;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_hilo_muldiv_ctrl: randomized bench with an arithmetic model. Rev 1.0
// ------------------------------------------------------------------
module tb_hilo_muldiv_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        rd = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic        stall, busy, done, dbz;
  logic [31:0] hi, lo;

  int          vectors = 0;
  int          errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  hilo_muldiv_ctrl #(.WIDTH(32)) dut (
    .CLOCK         (clk),
    .RESET         (rst_n),
    .Start_IN      (start),
    .Op_IN         (op),
    .OperandA_IN   (opa),
    .OperandB_IN   (opb),
    .ReadHiLo_IN   (rd),
    .Flush_IN      (flush),
    .Stall_OUT     (stall),
    .Busy_OUT      (busy),
    .Done_OUT      (done),
    .DivByZero_OUT (dbz),
    .HI_OUT        (hi),
    .LO_OUT        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Architectural effect of one op on HI/LO, straight from the ISA arithmetic.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      3'd0: begin p = sa * sb; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      3'd1: begin p = ua * ub; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      3'd2, 3'd3: begin
        if (b == 0) begin
          exp_hi = a;
          exp_lo = '1;
        end else if (o == 3'd2) begin
          p = sa / sb; exp_lo = p[31:0];
          p = sa % sb; exp_hi = p[31:0];
        end else begin
          p = ua / ub; exp_lo = p[31:0];
          p = ua % ub; exp_hi = p[31:0];
        end
      end
      3'd4: exp_hi = a;
      3'd5: exp_lo = a;
      default: ;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int cnt;
    model(o, a, b);
    op = o; opa = a; opb = b; start = 1'b1;
    tick();
    start = 1'b0;
    if (o <= 3'd1 || (o <= 3'd3 && b != 0)) begin
      check("busy_start", busy, 1);
      cnt = 1;
      while (!done && cnt < 60) begin
        tick();
        cnt++;
      end
      check("done_latency", cnt, 33);
      check("busy_in_fix", busy, 1);
      tick();
      check("busy_end", busy, 0);
      check("hi_result", hi, exp_hi);
      check("lo_result", lo, exp_lo);
    end else if (o <= 3'd3) begin
      check("dbz_pulse", dbz, 1);
      check("dbz_busy", busy, 0);
      check("dbz_hi", hi, exp_hi);
      check("dbz_lo", lo, exp_lo);
      tick();
      check("dbz_clear", dbz, 0);
    end else begin
      check("idle_busy", busy, 0);
      check("idle_hi", hi, exp_hi);
      check("idle_lo", lo, exp_lo);
    end
  endtask

  initial begin
    int cnt;
    logic seen;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_dbz", dbz, 0);
    rst_n = 1'b1;
    tick();

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd0, 32'hFFFF_FFFD, 32'd5);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd3, 32'd7, 32'd0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd4, 32'h0000_1234, 32'd0);

    // Dependent reads stall; an unrelated instruction does not.
    model(3'd1, 32'd3, 32'd4);
    op = 3'd1; opa = 32'd3; opb = 32'd4; start = 1'b1;
    tick();
    start = 1'b0; rd = 1'b1;
    cnt = 0;
    while (busy && cnt < 60) begin
      check("stall_read", stall, 1);
      if (cnt == 5) begin
        rd = 1'b0;
        #1;
        check("stall_indep", stall, 0);
        rd = 1'b1;
        #1;
      end
      tick();
      cnt++;
    end
    rd = 1'b0;
    check("stall_wait_bound", busy, 0);
    check("stall_lo", lo, exp_lo);

    // MTLO held behind a running multiply, then accepted once idle.
    model(3'd1, 32'd5, 32'd6);
    op = 3'd1; opa = 32'd5; opb = 32'd6; start = 1'b1;
    tick();
    op = 3'd5; opa = 32'h0000_ABCD;
    cnt = 0;
    while (busy && cnt < 60) begin
      check("mtlo_stall", stall, 1);
      tick();
      cnt++;
    end
    check("mtlo_wait_bound", busy, 0);
    check("mtlo_mul_lo", lo, exp_lo);
    model(3'd5, 32'h0000_ABCD, 32'd0);
    tick();
    start = 1'b0;
    check("mtlo_lo", lo, exp_lo);
    check("mtlo_hi", hi, exp_hi);

    // Start alongside a flush in idle is dropped.
    op = 3'd4; opa = 32'hDEAD_BEEF; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_idle_hi", hi, exp_hi);

    // Flush mid-sequence: abort, no write, no Done.
    op = 3'd1; opa = 32'd123; opb = 32'd456; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", busy, 0);
    seen = 1'b0;
    repeat (40) begin
      tick();
      seen = seen | done;
    end
    check("flush_no_done", seen, 0);
    check("flush_hi", hi, exp_hi);
    check("flush_lo", lo, exp_lo);

    // Asynchronous reset in the middle of a divide.
    op = 3'd2; opa = 32'd100; opb = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("areset_hi", hi, 0);
    check("areset_lo", lo, 0);
    check("areset_busy", busy, 0);
    exp_hi = '0;
    exp_lo = '0;
    #1;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 30; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'hF;
      run_op(ro, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
`default_nettype wire
